paddle_ctrl: RTL and testbench
==============================

PADDLE_CTRL -- requirements
Module: paddle_ctrl

Interface
REQ-001 SHALL have parameter STEP, default 4, meaning the digital-button paddle step in lines per frame (1..63).
REQ-002 SHALL have parameter DEADZONE, default 2, meaning the analog change, in counts, that is required to reclaim the source from digital.
REQ-003 SHALL have port clk_sys, input, width 1, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, width 1: synchronous, active-high reset.
REQ-005 SHALL have port vblank, input, width 1, the frame blanking flag, synchronous to clk_sys.
REQ-006 SHALL have port joy_analog_p1, input, width 8, the unsigned P1 analog position (0 = top).
REQ-007 SHALL have port joy_analog_p2, input, width 8, the unsigned P2 analog position.
REQ-008 SHALL have port btn_up, input, width 2, up buttons; bit 0 = P1, bit 1 = P2.
REQ-009 SHALL have port btn_down, input, width 2, down buttons; bit 0 = P1, bit 1 = P2.
REQ-010 SHALL have port paddle_vpos_p1, output, width 8, the P1 paddle position fed to the paddle 555 model.
REQ-011 SHALL have port paddle_vpos_p2, output, width 8, the P2 paddle position.
REQ-012 SHALL have port src_digital, output, width 2, the active source per player (1 = buttons, 0 = analog).
REQ-013 SHALL have port frame_upd, output, width 1, a one-cycle pulse when both players have been updated.

Function
REQ-014 SHALL detect the vblank rising edge (vblank=1, registered vblank_d=0) in cycle N.
REQ-015 SHALL use the FSM states IDLE, UPD1, UPD2 and DONE, with transitions IDLE->UPD1 on the edge, UPD1->UPD2, UPD2->DONE and DONE->IDLE unconditionally.
REQ-016 SHALL make the P1 update visible at N+2 and the P2 update visible at N+3, with frame_upd high only in cycle N+3 (state DONE).
REQ-017 SHALL ignore vblank edges arriving in UPD1, UPD2 or DONE (no queueing).
REQ-018 SHALL hold the outputs constant outside UPD1/UPD2, so positions change only during blanking.
REQ-019 SHALL, per player in its update cycle, set source=digital if that player's btn_up or btn_down is asserted.
REQ-020 SHALL, when the source is digital and no button is asserted, switch the source to analog if |analog - analog_ref| > DEADZONE (strictly greater), with vpos taking the analog value in that same cycle.
REQ-021 SHALL, when the source is analog, load vpos = analog and analog_ref = analog; when the source is digital, keep analog_ref frozen.
REQ-022 SHALL, in digital mode, apply up only: vpos = max(vpos - step, 0); down only: vpos = min(vpos + step, 255); both or neither: no change.
REQ-023 SHALL compute step arithmetic at 9-bit width and saturate, never wrapping.
REQ-024 SHALL sample the buttons and analog inputs for a player only in that player's update cycle.

Reset
REQ-025 SHALL, on reset, set paddle_vpos_p1/p2 = 8'd128, analog_ref = 8'd128, src_digital = 2'b00, frame_upd = 0, state = IDLE, vblank_d = 0, and hold counters = 0.
REQ-026 SHALL, on reset asserted mid-update (UPD1/UPD2/DONE), abort the update and apply REQ-025 values on the next edge, with no frame_upd pulse.
REQ-027 SHALL not treat vblank already high at reset release as an edge; the first update follows the next rising edge.

Configuration
REQ-028 SHALL, with macro PADDLE_ACCEL_EN defined, keep a per-player 4-bit hold counter that increments per update while the same single direction is held, saturating at 15 and clearing on release, on both buttons pressed, or on a direction change.
REQ-029 SHALL, with PADDLE_ACCEL_EN defined, use step = STEP while the hold counter is < 8 and 2*STEP once it is >= 8.
REQ-030 SHALL, without PADDLE_ACCEL_EN, always use step = STEP and synthesize no hold counters.

Verification
REQ-031 SHALL verify: reset, then vblank 0->1 with analog_p1=200 and analog_p2=40 -> vpos_p1=200 at N+2, vpos_p2=40 at N+3, frame_upd high at N+3 only.
REQ-032 SHALL verify: P1 at vpos 2, btn_up[0] held over 2 frames -> src_digital[0]=1, vpos 0 then 0 (saturation, no wrap to 254).
REQ-033 SHALL verify: P2 digital at 100, buttons released, analog_p2 moves from ref 100 to 102 (1 frame) then to 103 (1 frame) -> stays digital at 102, switches at 103 with vpos_p2=103.
REQ-034 SHALL verify: a second vblank edge in cycle N+2 -> ignored, exactly one frame_upd pulse.
REQ-035 SHALL verify: reset asserted in UPD2 -> both vpos=128 and no frame_upd pulse.
REQ-036 SHALL verify, with PADDLE_ACCEL_EN defined: btn_down[0] held for 10 frames from 0 with STEP=4 -> vpos 4,8,...,32 over frames 1-8, then 40, 48 at frames 9-10; without the macro -> 40 at frame 10.

Source files
------------

// File: rtl/paddle_ctrl.sv
// -----------------------------------------------------------------------------
// paddle_ctrl
//
// Produces the two paddle positions that feed the paddle 555 timer model.
// Each player can steer with an analog control or with up/down buttons. The
// active source is chosen per player. Positions change only during vertical
// blanking: a rising edge of vblank starts a short sequence that updates P1,
// then P2, then pulses frame_upd once.
//
// Sequence (N = cycle in which the vblank rising edge is seen):
//   N+1 : state UPD1, P1 inputs sampled
//   N+2 : new P1 position visible, state UPD2, P2 inputs sampled
//   N+3 : new P2 position visible, state DONE, frame_upd = 1
//   N+4 : back to IDLE
//
// Optional feature: define PADDLE_ACCEL_EN to add per-player hold counters.
// A direction held for 8 or more consecutive updates then moves at 2*STEP.
// Without the macro the step is always STEP and no hold counters exist.
//
// Parameters:
//   STEP     - button step in lines per update (1..63)
//   DEADZONE - analog change, in counts, needed to reclaim the source from
//              the buttons (the change must be strictly greater)
//
// Ports:
//   clk_sys        in   system clock (rising edge)
//   reset          in   synchronous, active-high reset
//   vblank         in   frame blanking flag
//   joy_analog_p1  in   [7:0] P1 analog position (0 = top)
//   joy_analog_p2  in   [7:0] P2 analog position
//   btn_up         in   [1:0] up buttons   (bit0 = P1, bit1 = P2)
//   btn_down       in   [1:0] down buttons (bit0 = P1, bit1 = P2)
//   paddle_vpos_p1 out  [7:0] P1 paddle position
//   paddle_vpos_p2 out  [7:0] P2 paddle position
//   src_digital    out  [1:0] active source per player (1 = buttons)
//   frame_upd      out  one-cycle pulse after both players are updated
// -----------------------------------------------------------------------------
module paddle_ctrl #(
  parameter int STEP     = 4,
  parameter int DEADZONE = 2
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       vblank,
  input  logic [7:0] joy_analog_p1,
  input  logic [7:0] joy_analog_p2,
  input  logic [1:0] btn_up,
  input  logic [1:0] btn_down,
  output logic [7:0] paddle_vpos_p1,
  output logic [7:0] paddle_vpos_p2,
  output logic [1:0] src_digital,
  output logic       frame_upd
);

  typedef enum logic [1:0] {IDLE, UPD1, UPD2, DONE} state_t;

  // Everything that is remembered about one player between updates.
  typedef struct packed {
    logic [7:0] vpos;   // current paddle position
    logic [7:0] aref;   // analog value at the last analog-sourced update
    logic       src;    // 1 = buttons, 0 = analog
`ifdef PADDLE_ACCEL_EN
    logic [3:0] hold;   // consecutive updates with the same single direction
    logic       dir;    // direction counted by hold (1 = down)
`endif
  } player_t;

  state_t  r_state;
  logic    r_vblank_d;
  logic    r_armed;
  logic    r_frame_upd;
  player_t r_p1;
  player_t r_p2;

  logic    w_vb_rise;
  player_t w_p1_next;
  player_t w_p2_next;

  // One player's update: the buttons win, otherwise the analog control either
  // keeps or reclaims the source depending on how far it moved.
  function automatic player_t player_update(input player_t    cur,
                                            input logic       up,
                                            input logic       dn,
                                            input logic [7:0] ana);
    player_t    nxt;
    logic [8:0] step9;
    logic [8:0] diff9;
    logic [8:0] sum9;
    logic [8:0] dist9;

    nxt   = cur;
    step9 = 9'(STEP);

`ifdef PADDLE_ACCEL_EN
    if (up ^ dn) begin
      if ((cur.hold != 4'd0) && (cur.dir == dn)) begin
        if (cur.hold >= 4'd8)
          step9 = 9'(2 * STEP);
        if (cur.hold != 4'd15)
          nxt.hold = cur.hold + 4'd1;
      end else begin
        // A fresh press or a direction change counts as the first held update.
        nxt.hold = 4'd1;
      end
      nxt.dir = dn;
    end else begin
      nxt.hold = 4'd0;
    end
`endif

    // Nine-bit arithmetic: bit 8 flags a borrow or carry so the result
    // saturates instead of wrapping.
    diff9 = {1'b0, cur.vpos} - step9;
    sum9  = {1'b0, cur.vpos} + step9;
    dist9 = (ana >= cur.aref) ? ({1'b0, ana} - {1'b0, cur.aref})
                              : ({1'b0, cur.aref} - {1'b0, ana});

    if (up || dn) begin
      nxt.src = 1'b1;
      if (up && !dn)
        nxt.vpos = diff9[8] ? 8'd0 : diff9[7:0];
      else if (dn && !up)
        nxt.vpos = sum9[8] ? 8'd255 : sum9[7:0];
    end else if (!cur.src || (dist9 > 9'(DEADZONE))) begin
      // Analog is (or becomes) the source; its reference tracks it. While the
      // buttons own the source the reference stays frozen.
      nxt.src  = 1'b0;
      nxt.vpos = ana;
      nxt.aref = ana;
    end
    return nxt;
  endfunction

  // A vblank already high when reset releases must not count as an edge:
  // r_armed masks the single cycle in which r_vblank_d is still forced low.
  assign w_vb_rise = vblank && !r_vblank_d && r_armed;

  // NOTE: combinational blocks assign every output on every path (here via a
  // function with a full default) so no latch is inferred.
  always_comb begin
    w_p1_next = player_update(r_p1, btn_up[0], btn_down[0], joy_analog_p1);
    w_p2_next = player_update(r_p2, btn_up[1], btn_down[1], joy_analog_p2);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state     <= IDLE;
      r_vblank_d  <= 1'b0;
      r_armed     <= 1'b0;
      r_frame_upd <= 1'b0;
      r_p1.vpos   <= 8'd128;
      r_p1.aref   <= 8'd128;
      r_p1.src    <= 1'b0;
      r_p2.vpos   <= 8'd128;
      r_p2.aref   <= 8'd128;
      r_p2.src    <= 1'b0;
`ifdef PADDLE_ACCEL_EN
      r_p1.hold   <= 4'd0;
      r_p1.dir    <= 1'b0;
      r_p2.hold   <= 4'd0;
      r_p2.dir    <= 1'b0;
`endif
    end else begin
      r_vblank_d  <= vblank;
      r_armed     <= 1'b1;
      r_frame_upd <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_vb_rise)
            r_state <= UPD1;
        end
        UPD1: begin
          r_p1    <= w_p1_next;
          r_state <= UPD2;
        end
        UPD2: begin
          r_p2        <= w_p2_next;
          r_frame_upd <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign paddle_vpos_p1 = r_p1.vpos;
  assign paddle_vpos_p2 = r_p2.vpos;
  assign src_digital    = {r_p2.src, r_p1.src};
  assign frame_upd      = r_frame_upd;

endmodule

// File: tb/tb_paddle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_paddle_ctrl
//
// Directed test of paddle_ctrl (STEP = 4, DEADZONE = 2). Each frame pushes its
// hand-computed result into a scoreboard queue; a monitor pops and compares
// whenever frame_upd pulses. Stimulus tasks also check the cycle-by-cycle
// timing of each update and the reset behaviour.
// -----------------------------------------------------------------------------
module tb_paddle_ctrl;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       vblank;
  logic [7:0] joy_analog_p1;
  logic [7:0] joy_analog_p2;
  logic [1:0] btn_up;
  logic [1:0] btn_down;
  logic [7:0] paddle_vpos_p1;
  logic [7:0] paddle_vpos_p2;
  logic [1:0] src_digital;
  logic       frame_upd;

  typedef struct {
    logic [7:0] p1;
    logic [7:0] p2;
    logic [1:0] src;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_pulses = 0;
  logic [7:0] m_p1 = 8'd128;
  logic [7:0] m_p2 = 8'd128;

  paddle_ctrl #(.STEP(4), .DEADZONE(2)) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .vblank         (vblank),
    .joy_analog_p1  (joy_analog_p1),
    .joy_analog_p2  (joy_analog_p2),
    .btn_up         (btn_up),
    .btn_down       (btn_down),
    .paddle_vpos_p1 (paddle_vpos_p1),
    .paddle_vpos_p2 (paddle_vpos_p2),
    .src_digital    (src_digital),
    .frame_upd      (frame_upd)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every frame_upd pulse must match the oldest expected frame.
  always @(negedge clk_sys) begin
    if (frame_upd === 1'b1) begin
      n_pulses++;
      if (sb_q.size() == 0) begin
        check("sb_unexpected_pulse", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_vpos_p1", paddle_vpos_p1, e.p1);
        check("sb_vpos_p2", paddle_vpos_p2, e.p2);
        check("sb_src",     src_digital,    e.src);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // One full update with timing checks; inputs must already be set.
  task automatic run_frame(input string tag, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [1:0] es);
    exp_t e;
    e.p1 = e1; e.p2 = e2; e.src = es;
    sb_q.push_back(e);
    vblank = 1'b1;
    tick();                      // N+1: UPD1
    tick();                      // N+2: P1 updated, P2 not yet
    check({tag, "_p1_at_n2"}, paddle_vpos_p1, e1);
    check({tag, "_p2_held_n2"}, paddle_vpos_p2, m_p2);
    check({tag, "_upd_low_n2"}, frame_upd, 1'b0);
    tick();                      // N+3: DONE
    check({tag, "_p2_at_n3"}, paddle_vpos_p2, e2);
    check({tag, "_upd_high_n3"}, frame_upd, 1'b1);
    tick();                      // N+4
    check({tag, "_upd_low_n4"}, frame_upd, 1'b0);
    vblank = 1'b0;
    tick();
    tick();
    m_p1 = e1;
    m_p2 = e2;
  endtask

  function automatic logic [7:0] accel_exp(input int k);
`ifdef PADDLE_ACCEL_EN
    return (k <= 8) ? 8'(4 * k) : 8'(32 + 8 * (k - 8));
`else
    return 8'(4 * k);
`endif
  endfunction

  initial begin
    int pulses_before;

    reset = 1'b1; vblank = 1'b1;
    joy_analog_p1 = 8'd0; joy_analog_p2 = 8'd0;
    btn_up = 2'b00; btn_down = 2'b00;

    // Reset values, with vblank already high across reset release.
    tick(); tick(); tick();
    check("rst_vpos_p1", paddle_vpos_p1, 8'd128);
    check("rst_vpos_p2", paddle_vpos_p2, 8'd128);
    check("rst_src",     src_digital,    2'b00);
    check("rst_upd",     frame_upd,      1'b0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("no_edge_at_release", n_pulses, 0);
    check("no_edge_vpos_p1", paddle_vpos_p1, 8'd128);
    vblank = 1'b0;
    tick(); tick();

    // Basic analog update.
    joy_analog_p1 = 8'd200; joy_analog_p2 = 8'd40;
    run_frame("analog", 8'd200, 8'd40, 2'b00);

    // P1 at 2, up held two frames: saturates at 0.
    joy_analog_p1 = 8'd2;
    run_frame("p1_to_2", 8'd2, 8'd40, 2'b00);
    btn_up = 2'b01;
    run_frame("up_sat1", 8'd0, 8'd40, 2'b01);
    run_frame("up_sat2", 8'd0, 8'd40, 2'b01);
    btn_up = 2'b00;

    // P2 to 100 via analog, then both buttons: digital, no move.
    joy_analog_p2 = 8'd100;
    run_frame("p2_to_100", 8'd0, 8'd100, 2'b01);
    btn_up = 2'b10; btn_down = 2'b10;
    run_frame("p2_both", 8'd0, 8'd100, 2'b11);
    btn_up = 2'b00; btn_down = 2'b00;
    joy_analog_p2 = 8'd102;
    run_frame("dz_102", 8'd0, 8'd100, 2'b11);
    joy_analog_p2 = 8'd103;
    run_frame("dz_103", 8'd0, 8'd103, 2'b01);

    // Second vblank edge in N+2 is ignored.
    joy_analog_p1 = 8'd50; joy_analog_p2 = 8'd60;
    pulses_before = n_pulses;
    begin
      exp_t e;
      e.p1 = 8'd50; e.p2 = 8'd60; e.src = 2'b00;
      sb_q.push_back(e);
    end
    vblank = 1'b1;
    tick();                      // N+1
    vblank = 1'b0;
    tick();                      // N+2
    vblank = 1'b1;               // rises during N+2
    for (int i = 0; i < 10; i++) tick();
    check("double_edge_pulses", n_pulses - pulses_before, 1);
    vblank = 1'b0;
    tick(); tick();
    m_p1 = 8'd50; m_p2 = 8'd60;

    // Reset during UPD2: no pulse, back to 128.
    joy_analog_p1 = 8'd10; joy_analog_p2 = 8'd20;
    pulses_before = n_pulses;
    vblank = 1'b1;
    tick();                      // N+1: UPD1
    vblank = 1'b0;
    tick();                      // N+2: UPD2
    check("abort_p1_n2", paddle_vpos_p1, 8'd10);
    reset = 1'b1;
    tick();
    check("abort_vpos_p1", paddle_vpos_p1, 8'd128);
    check("abort_vpos_p2", paddle_vpos_p2, 8'd128);
    check("abort_src",     src_digital,    2'b00);
    check("abort_upd",     frame_upd,      1'b0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("abort_no_pulse", n_pulses - pulses_before, 0);
    m_p1 = 8'd128; m_p2 = 8'd128;

    // Down held for 10 frames from 0.
    joy_analog_p1 = 8'd0;
    run_frame("p1_to_0", 8'd0, 8'd20, 2'b00);
    btn_down = 2'b01;
    for (int k = 1; k <= 10; k++)
      run_frame($sformatf("hold_f%0d", k), accel_exp(k), 8'd20, 2'b01);
    btn_down = 2'b00;

    tick(); tick();
    check("sb_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
